switch_bounce_gen: RTL
======================

Name: switch_bounce_gen

Overview:
- Synthesizable mechanical-switch emulator: turns a clean level command into a bouncy contact waveform. It is the driving end of the debouncer interface.
- Feeds debouncer input `signal` in on-chip loopback/self-test of PLL control switches and in benches.
- Bounce intervals come from a 16-bit LFSR, so waveforms are repeatable for a given seed.

Parameters:
- BOUNCES, 5: number of bounce pulses per transition (0 allowed).
- MIN_GAP, 4: minimum phase length in clk cycles (>=1).
- GAP_MASK, 7: random extension mask; must be 2^k-1, <=255.
- SETTLE, 16: cycles bounce_out holds the final level with busy high before done (>=1).
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- INIT_LEVEL, 1'b1: bounce_out value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- sw_in  input  1  clean requested switch level.
- bounce_en  input  1  1 = emulate bounce; 0 = pass-through.
- bounce_out  output  1  emulated contact signal, registered.
- busy  output  1  high while a bounce/settle sequence is in progress.
- done  output  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (rst=1 at a clk edge):
  - bounce_out=INIT_LEVEL, busy=0, done=0, lfsr=SEED, state=IDLE, all counters 0.
  - Reset mid-sequence aborts it immediately, with no done pulse.
- LFSR:
  - Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form, shifting left; new bit = l[15]^l[13]^l[12]^l[10].
  - Advances only when a phase length is loaded, never on idle cycles.
  - gap = MIN_GAP + (lfsr[7:0] & GAP_MASK), computed from the pre-advance value.
- States: IDLE, BOUNCE_NEW, BOUNCE_OLD, SETTLE.
- IDLE:
  - busy=0. If sw_in != bounce_out, latch target=sw_in.
  - If bounce_en=0: bounce_out<=sw_in, stay IDLE, no busy, no done (1-cycle latency).
  - Else if BOUNCES>0: bounce_out<=target, load gap, pulse count=0, go BOUNCE_NEW.
  - Else (BOUNCES=0): bounce_out<=target, go SETTLE.
  - busy asserts on the same edge bounce_out first changes.
- BOUNCE_NEW: bounce_out=target for exactly gap cycles, then bounce_out<=~target, load new gap, go BOUNCE_OLD.
- BOUNCE_OLD:
  - bounce_out=~target for exactly gap cycles, then bounce_out<=target and increment pulse count.
  - If count==BOUNCES, go SETTLE; else load new gap and go BOUNCE_NEW.
- SETTLE:
  - bounce_out=target for exactly SETTLE cycles, busy=1.
  - Then busy<=0, done<=1 for one cycle, go IDLE.
- Total busy time = sum of 2*BOUNCES gaps + SETTLE cycles.
- sw_in changes while busy are ignored; target stays fixed.
  - On return to IDLE, if sw_in != bounce_out, a new sequence starts on the following edge.
  - done and the restart transition may be back-to-back.
- bounce_en is sampled only in IDLE; deasserting it mid-sequence has no effect until IDLE.
- Counters: gap counter 9 bits; pulse counter clog2(BOUNCES+1) bits, min 1. No wrap-around is possible within legal parameters.
- bounce_out is glitch-free: driven directly from a flop.

Test Plan:
- Reset/pass-through: rst 3 cycles, bounce_en=0, toggle sw_in 1->0->1 -> bounce_out=1 after reset, then follows sw_in 1 cycle late; busy=0, done never pulses.
- Deterministic bounce: BOUNCES=2, MIN_GAP=4, GAP_MASK=0, SETTLE=16, INIT=0; sw_in 0->1.
  - bounce_out: 1 for 4 cycles, 0x4, 1x4, 0x4, then 1 steady.
  - busy high 32 cycles; done pulses on cycle 33.
- Randomized gaps: defaults, SEED=16'hACE1 -> every phase length lies in [4,11].
  - Sequence matches the reference LFSR model; two runs with the same seed give identical waveforms.
- Change while busy: during the deterministic case, pulse sw_in 1->0->1 mid-bounce -> no effect.
  - Then set sw_in=0 before done -> new 1->0 sequence starts the cycle after done.
- BOUNCES=0: sw_in 0->1 -> bounce_out=1 next cycle, busy for SETTLE=16 cycles, then done; no toggles.
- Reset mid-sequence: assert rst during BOUNCE_OLD -> next cycle bounce_out=INIT_LEVEL, busy=0, no done, lfsr=SEED.

Source files
------------

// File: rtl/switch_bounce_gen.sv
// Mechanical-switch emulator: turns a clean level command into a bouncy contact
// waveform whose phase lengths come from a 16-bit LFSR.
module switch_bounce_gen #(
    parameter int          BOUNCES    = 5,
    parameter int          MIN_GAP    = 4,
    parameter int          GAP_MASK   = 7,
    parameter int          SETTLE     = 16,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic        INIT_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    input  logic bounce_en,
    output logic bounce_out,
    output logic busy,
    output logic done
);

    localparam int             PW         = (BOUNCES > 0) ? $clog2(BOUNCES + 1) : 1;
    localparam logic [PW-1:0]  LAST_PULSE = (BOUNCES > 0) ? PW'(BOUNCES - 1) : {PW{1'b0}};
    localparam logic [8:0]     MIN_GAP_W  = 9'(MIN_GAP);
    localparam logic [8:0]     SETTLE_W   = 9'(SETTLE);
    localparam logic [7:0]     GAP_MASK_W = 8'(GAP_MASK);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BOUNCE_NEW = 2'd1,
        ST_BOUNCE_OLD = 2'd2,
        ST_SETTLE     = 2'd3
    } state_t;

    // x^16+x^14+x^13+x^11+1, Fibonacci form, shifting left
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [8:0] gap_len(input logic [15:0] l);
        return MIN_GAP_W + {1'b0, l[7:0] & GAP_MASK_W};
    endfunction

    state_t        state_r, state_s;
    logic          bounce_out_r, bounce_out_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          target_r, target_s;
    logic [15:0]   lfsr_r, lfsr_s;
    logic [8:0]    gap_cnt_r, gap_cnt_s;
    logic [PW-1:0] pulse_cnt_r, pulse_cnt_s;

    // State and output registers; reset aborts any sequence without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            bounce_out_r <= INIT_LEVEL;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            target_r     <= INIT_LEVEL;
            lfsr_r       <= SEED;
            gap_cnt_r    <= 9'd0;
            pulse_cnt_r  <= {PW{1'b0}};
        end else begin
            state_r      <= state_s;
            bounce_out_r <= bounce_out_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            target_r     <= target_s;
            lfsr_r       <= lfsr_s;
            gap_cnt_r    <= gap_cnt_s;
            pulse_cnt_r  <= pulse_cnt_s;
        end
    end

    // Next-state logic; a phase ends on the cycle its counter reads 1
    always_comb begin
        state_s      = state_r;
        bounce_out_s = bounce_out_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        target_s     = target_r;
        lfsr_s       = lfsr_r;
        gap_cnt_s    = gap_cnt_r;
        pulse_cnt_s  = pulse_cnt_r;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (sw_in != bounce_out_r) begin
                    target_s     = sw_in;
                    bounce_out_s = sw_in;
                    if (!bounce_en) begin
                        state_s = ST_IDLE;
                    end else if (BOUNCES > 0) begin
                        busy_s      = 1'b1;
                        gap_cnt_s   = gap_len(lfsr_r);
                        lfsr_s      = lfsr_next(lfsr_r);
                        pulse_cnt_s = {PW{1'b0}};
                        state_s     = ST_BOUNCE_NEW;
                    end else begin
                        busy_s    = 1'b1;
                        gap_cnt_s = SETTLE_W;
                        state_s   = ST_SETTLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BOUNCE_NEW: begin
                if (gap_cnt_r <= 9'd1) begin
                    bounce_out_s = ~target_r;
                    gap_cnt_s    = gap_len(lfsr_r);
                    lfsr_s       = lfsr_next(lfsr_r);
                    state_s      = ST_BOUNCE_OLD;
                end else begin
                    gap_cnt_s = gap_cnt_r - 9'd1;
                end
            end
            ST_BOUNCE_OLD: begin
                if (gap_cnt_r <= 9'd1) begin
                    bounce_out_s = target_r;
                    pulse_cnt_s  = pulse_cnt_r + PW'(1);
                    if (pulse_cnt_r == LAST_PULSE) begin
                        gap_cnt_s = SETTLE_W;
                        state_s   = ST_SETTLE;
                    end else begin
                        gap_cnt_s = gap_len(lfsr_r);
                        lfsr_s    = lfsr_next(lfsr_r);
                        state_s   = ST_BOUNCE_NEW;
                    end
                end else begin
                    gap_cnt_s = gap_cnt_r - 9'd1;
                end
            end
            ST_SETTLE: begin
                if (gap_cnt_r <= 9'd1) begin
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - 9'd1;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    assign bounce_out = bounce_out_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
